// File: rtl/fetch_unit.sv
// fetch_unit: fetch sequencer driving the core's DIN/Run from a sync ROM.
// Optional watchdog (Fault on a hung instruction): define FETCH_WATCHDOG_EN.
module fetch_unit #(
   parameter int                ADDR_W      = 8,
   parameter logic [ADDR_W-1:0] START_ADDR  = '0,
   parameter logic [3:0]        MVI_OP      = 4'b0100,
   parameter logic [3:0]        HALT_OP     = 4'b1111,
   parameter int                WDOG_CYCLES = 16
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Enable,
   output logic [ADDR_W-1:0] MemAddr,
   input  logic [15:0]       MemData,
   output logic [15:0]       DIN,
   output logic              Run,
   input  logic              Done,
   output logic [ADDR_W-1:0] PC,
   output logic              Halted,
   output logic              Fault
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      FETCH_IMM,
      LOAD_IMM,
      EXEC,
      HALT,
      ERROR
   } state_t;

   state_t      state;
   logic [15:0] instr_q;
   logic [15:0] imm_q;
   logic        first_q;
   logic [3:0]  op;

   assign op = MemData[9:6];

   if (WDOG_CYCLES < 4) begin : g_bad_wdog
      $error("WDOG_CYCLES must be at least 4");
   end

`ifdef FETCH_WATCHDOG_EN
   localparam int CW = $clog2(WDOG_CYCLES);
   localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_CYCLES - 1);

   logic [CW-1:0] wdog_cnt;
   logic          fault_q;

   assign Fault = fault_q;
`else
   assign Fault = 1'b0;
`endif

   // Main sequencer: fetch word, optionally prefetch immediate, hold Run
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         PC      <= START_ADDR;
         MemAddr <= '0;
         DIN     <= '0;
         Run     <= 1'b0;
         Halted  <= 1'b0;
         instr_q <= '0;
         imm_q   <= '0;
         first_q <= 1'b0;
`ifdef FETCH_WATCHDOG_EN
         wdog_cnt <= '0;
         fault_q  <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               Run <= 1'b0;
               if (Enable) state <= FETCH;
            end
            FETCH: begin
               MemAddr <= PC;
               state   <= LOAD;
            end
            LOAD: begin
               instr_q <= MemData;
               PC      <= PC + 1'b1;
               if (op == HALT_OP) begin
                  Halted <= 1'b1;
                  state  <= HALT;
               end else if (op == MVI_OP) begin
                  state <= FETCH_IMM;
               end else begin
                  DIN     <= MemData;
                  Run     <= 1'b1;
                  first_q <= 1'b1;
`ifdef FETCH_WATCHDOG_EN
                  wdog_cnt <= '0;
`endif
                  state   <= EXEC;
               end
            end
            FETCH_IMM: begin
               MemAddr <= PC;
               state   <= LOAD_IMM;
            end
            LOAD_IMM: begin
               imm_q   <= MemData;
               PC      <= PC + 1'b1;
               DIN     <= instr_q;
               Run     <= 1'b1;
               first_q <= 1'b1;
`ifdef FETCH_WATCHDOG_EN
               wdog_cnt <= '0;
`endif
               state   <= EXEC;
            end
            EXEC: begin
               first_q <= 1'b0;
               // core reads the immediate from its step-1 cycle on
               if (first_q && instr_q[9:6] == MVI_OP)
                  DIN <= imm_q;
               if (Done) begin
                  Run   <= 1'b0;
                  state <= Enable ? FETCH : IDLE;
               end
`ifdef FETCH_WATCHDOG_EN
               else if (wdog_cnt == WDOG_LAST) begin
                  Run     <= 1'b0;
                  fault_q <= 1'b1;
                  state   <= ERROR;
               end else begin
                  wdog_cnt <= wdog_cnt + 1'b1;
               end
`endif
            end
            HALT: begin
               Run <= 1'b0;
            end
            ERROR: begin
               Run <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: program-level model of issued words vs. fetch_unit.
// Second instance covers a 2-bit PC wrapping through an mvi immediate.
module tb_fetch_unit;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] imm;
      bit          mvi;
      int          len;
      logic [7:0]  pc_after;
   } issue_t;

   localparam logic [15:0] W_HALT = 16'h03C0;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Enable0 = 1'b0;
   logic        Enable1 = 1'b0;
   logic        Done0 = 1'b0;
   logic        Done1 = 1'b0;
   logic [7:0]  MemAddr0;
   logic [7:0]  PC0;
   logic [15:0] MemData0, DIN0;
   logic        Run0, Halted0, Fault0;
   logic [1:0]  MemAddr1, PC1;
   logic [15:0] MemData1, DIN1;
   logic        Run1, Halted1, Fault1;

   logic [15:0] rom0 [256];
   logic [15:0] rom1 [4];

   int n_cmp = 0;
   int n_bad = 0;

   issue_t exp_q[$];
   issue_t cur;
   bit     have_cur = 0;
   bit     mon_en = 0;
   bit     first_issue = 1;
   bit     run_prev = 0;
   int     low_cnt = 0;
   int     run_len = 0;
   int     n_issue = 0;
   int     done_at = 0;
   int     run_cyc = 0;

   always #5 Clock = ~Clock;

   assign MemData0 = rom0[MemAddr0];
   assign MemData1 = rom1[MemAddr1];

   fetch_unit #(
      .ADDR_W(8), .START_ADDR(8'd0), .WDOG_CYCLES(8)
   ) u0 (
      .Clock(Clock), .Reset(Reset), .Enable(Enable0),
      .MemAddr(MemAddr0), .MemData(MemData0), .DIN(DIN0),
      .Run(Run0), .Done(Done0), .PC(PC0),
      .Halted(Halted0), .Fault(Fault0)
   );

   fetch_unit #(
      .ADDR_W(2), .START_ADDR(2'd3), .WDOG_CYCLES(8)
   ) u1 (
      .Clock(Clock), .Reset(Reset), .Enable(Enable1),
      .MemAddr(MemAddr1), .MemData(MemData1), .DIN(DIN1),
      .Run(Run1), .Done(Done1), .PC(PC1),
      .Halted(Halted1), .Fault(Fault1)
   );

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected issue list from walking the ROM image
   task automatic plan(input logic [7:0] pc0, input int len);
      logic [7:0] pc;
      issue_t t;
      pc = pc0;
      exp_q.delete();
      for (int k = 0; k < 8; k++) begin
         t.instr = rom0[pc];
         pc = pc + 8'd1;
         if (t.instr[9:6] == 4'b1111) break;
         t.mvi = (t.instr[9:6] == 4'b0100);
         t.imm = t.mvi ? rom0[pc] : t.instr;
         if (t.mvi) pc = pc + 8'd1;
         t.len = len;
         t.pc_after = pc;
         exp_q.push_back(t);
      end
   endtask

   task automatic load_rom();
      for (int i = 0; i < 256; i++) rom0[i] = W_HALT;
   endtask

   task automatic do_reset();
      mon_en = 0;
      Reset = 1;
      Enable0 = 0;
      Enable1 = 0;
      Done1 = 0;
      repeat (2) @(posedge Clock);
      #1;
      Reset = 0;
      have_cur = 0;
      first_issue = 1;
      n_issue = 0;
   endtask

   task automatic wait_run(input string nm, input int exp);
      int e;
      e = 0;
      do begin
         @(posedge Clock);
         #1;
         e++;
      end while (!Run0 && e < 40);
      check(nm, e, exp);
   endtask

   task automatic wait_fall(input string nm);
      int e;
      e = 0;
      while (Run0 && e < 60) begin
         @(posedge Clock);
         #1;
         e++;
      end
      check(nm, Run0, 0);
   endtask

   task automatic wait_halt(input string nm);
      int e;
      e = 0;
      while (!Halted0 && e < 60) begin
         @(posedge Clock);
         #1;
         e++;
      end
      check(nm, Halted0, 1);
   endtask

   // Core stand-in: Done in the done_at-th Run cycle (0 = never)
   always @(negedge Clock) begin
      if (Run0) begin
         run_cyc++;
         Done0 = (done_at != 0 && run_cyc == done_at);
      end else begin
         run_cyc = 0;
         Done0 = 0;
      end
   end

   // Compare process against the planned issue list
   always @(negedge Clock) begin
      if (mon_en) begin
         if (Run0 && !run_prev) begin
            n_issue++;
            if (!first_issue) check("run_gap", low_cnt >= 2, 1);
            first_issue = 0;
            if (exp_q.size() == 0) begin
               check("issue_extra", exp_q.size(), 1);
            end else begin
               cur = exp_q.pop_front();
               have_cur = 1;
               check("issue_din", DIN0, cur.instr);
            end
            run_len = 1;
         end else if (Run0 && have_cur) begin
            run_len++;
            check("exec_din", DIN0, cur.mvi ? cur.imm : cur.instr);
         end else if (!Run0 && run_prev && have_cur) begin
            check("run_len", run_len, cur.len);
            check("pc_after", PC0, {24'd0, cur.pc_after});
            have_cur = 0;
         end
         check("halt_quiet", Run0 & Halted0, 0);
      end
      low_cnt = Run0 ? 0 : low_cnt + 1;
      run_prev = Run0;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int e;
      load_rom();
      rom1[0] = 16'h1234;
      rom1[1] = W_HALT;
      rom1[2] = W_HALT;
      rom1[3] = 16'h0105;
      do_reset();

      // reset values
      check("rst_run", Run0, 0);
      check("rst_din", DIN0, 0);
      check("rst_pc", PC0, 0);
      check("rst_maddr", MemAddr0, 0);
      check("rst_halted", Halted0, 0);
      check("rst_fault", Fault0, 0);
      check("rst_pc1", PC1, 3);
      check("rst_maddr1", MemAddr1, 0);

      // mv then halt, Done in 2nd EXEC cycle
      load_rom();
      rom0[0] = 16'h00C9;
      done_at = 2;
      plan(8'd0, 2);
      mon_en = 1;
      @(negedge Clock);
      Enable0 = 1;
      wait_run("lat_mv", 3);
      check("din_mv", DIN0, 16'h00C9);
      wait_halt("halt_mv");
      check("pc_mv", PC0, 2);
      repeat (5) @(posedge Clock);
      #1;
      check("run_after_halt", Run0, 0);
      check("q_empty_mv", exp_q.size(), 0);
      check("issues_mv", n_issue, 1);

      // mvi with immediate, Done after 4 EXEC cycles
      do_reset();
      load_rom();
      rom0[0] = 16'h0112;
      rom0[1] = 16'hBEEF;
      done_at = 4;
      plan(8'd0, 4);
      mon_en = 1;
      @(negedge Clock);
      Enable0 = 1;
      wait_run("lat_mvi", 5);
      check("mvi_c1", DIN0, 16'h0112);
      @(posedge Clock);
      #1;
      check("mvi_c2", DIN0, 16'hBEEF);
      wait_fall("mvi_fall");
      check("pc_mvi", PC0, 2);
      wait_halt("halt_mvi");
      check("q_empty_mvi", exp_q.size(), 0);

      // reset in 3rd EXEC cycle, then restart
      do_reset();
      load_rom();
      rom0[0] = 16'h00C1;
      rom0[1] = 16'h00C2;
      done_at = 0;
      plan(8'd0, 0);
      mon_en = 1;
      @(negedge Clock);
      Enable0 = 1;
      wait_run("lat_r", 3);
      repeat (2) @(posedge Clock);
      #1;
      mon_en = 0;
      Reset = 1;
      done_at = 2;
      @(posedge Clock);
      #1;
      check("rst_mid_run", Run0, 0);
      check("rst_mid_pc", PC0, 0);
      Reset = 0;
      have_cur = 0;
      first_issue = 1;
      plan(8'd0, 2);
      mon_en = 1;
      wait_run("lat_restart", 3);
      check("din_restart", DIN0, 16'h00C1);
      wait_halt("halt_restart");
      check("pc_restart", PC0, 3);
      check("q_empty_r", exp_q.size(), 0);

      // Enable dropped mid-EXEC, Done two cycles later
      do_reset();
      load_rom();
      rom0[0] = 16'h00C3;
      rom0[1] = 16'h00C4;
      done_at = 3;
      plan(8'd0, 3);
      mon_en = 1;
      @(negedge Clock);
      Enable0 = 1;
      wait_run("lat_en", 3);
      Enable0 = 0;
      wait_fall("en_fall");
      repeat (4) @(posedge Clock);
      #1;
      check("en_idle_run", Run0, 0);
      check("en_idle_pc", PC0, 1);
      @(negedge Clock);
      Enable0 = 1;
      wait_run("lat_resume", 3);
      check("din_resume", DIN0, 16'h00C4);
      wait_halt("halt_en");
      check("pc_en", PC0, 3);
      check("q_empty_en", exp_q.size(), 0);

`ifdef FETCH_WATCHDOG_EN
      // watchdog expiry with no Done
      do_reset();
      load_rom();
      rom0[0] = 16'h00C5;
      done_at = 0;
      plan(8'd0, 8);
      mon_en = 1;
      @(negedge Clock);
      Enable0 = 1;
      wait_run("lat_wd", 3);
      wait_fall("wd_fall");
      check("wd_fault", Fault0, 1);
      check("wd_halted", Halted0, 0);
      repeat (3) @(posedge Clock);
      #1;
      check("wd_stuck", Run0, 0);

      // Done in the limit cycle wins
      do_reset();
      load_rom();
      rom0[0] = 16'h00C5;
      done_at = 8;
      plan(8'd0, 8);
      mon_en = 1;
      @(negedge Clock);
      Enable0 = 1;
      wait_run("lat_wd8", 3);
      wait_halt("halt_wd8");
      check("wd8_fault", Fault0, 0);
      check("q_empty_wd8", exp_q.size(), 0);
`else
      // without the watchdog a hung instruction just waits
      do_reset();
      load_rom();
      rom0[0] = 16'h00C5;
      done_at = 0;
      plan(8'd0, 0);
      mon_en = 1;
      @(negedge Clock);
      Enable0 = 1;
      wait_run("lat_nowd", 3);
      repeat (20) @(posedge Clock);
      #1;
      check("nowd_run", Run0, 1);
      check("nowd_fault", Fault0, 0);
`endif

      // 2-bit PC: mvi at 3, immediate wraps to address 0
      do_reset();
      done_at = 0;
      @(negedge Clock);
      Enable1 = 1;
      e = 0;
      do begin
         @(posedge Clock);
         #1;
         e++;
      end while (!Run1 && e < 40);
      check("lat_wrap", e, 5);
      check("wrap_c1", DIN1, 16'h0105);
      check("wrap_imm_addr", MemAddr1, 0);
      @(posedge Clock);
      #1;
      check("wrap_c2", DIN1, 16'h1234);
      Done1 = 1;
      @(posedge Clock);
      #1;
      Done1 = 0;
      check("wrap_fall", Run1, 0);
      check("wrap_pc", PC1, 1);
      repeat (4) @(posedge Clock);
      #1;
      check("wrap_halted", Halted1, 1);
      check("wrap_pc_halt", PC1, 2);
      check("wrap_fault", Fault1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
